// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer: selects the next PC from the
// sequential, branch, jump and trap sources and runs the imem ready/stall/flush handshake.
module pc_fetch_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     INC      = 4,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            inst_valid,
  output logic            flush,
  output logic            fetch_timeout,
  output logic [15:0]     redirect_count
);

  localparam int unsigned     WaitW  = $clog2(MAX_WAIT + 1);
  localparam logic [XLEN-1:0] IncVal = XLEN'(INC);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  typedef enum logic [1:0] {StBoot, StFetch, StHold, StFlush} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d;
  logic              imem_req_q, imem_req_d;
  logic              flush_q, flush_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       count_q, count_d;
  logic [WaitW-1:0]  wait_q, wait_d;

  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;

  always_comb begin
    redirect    = trap | jump | branch_taken;
    redirect_pc = trap ? TRAP_VEC : (jump ? jump_target : branch_target);
    redirect_pc[1:0] = 2'b00;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;

    unique case (state_q)
      StBoot: begin
        state_d = StFetch;
        wait_d  = '0;
      end
      StFetch: begin
        if (imem_ready) begin
          wait_d = '0;
          if (stall) begin
            state_d = StHold;
          end else begin
            pc_d = pc_q + IncVal;
          end
        end else begin
          // Saturate so a long stall never wraps the counter back below the threshold.
          wait_d = (wait_q == WaitMax) ? wait_q : wait_q + 1'b1;
          if (wait_d == WaitMax) begin
            timeout_d = 1'b1;
          end
        end
      end
      StHold: begin
        wait_d = '0;
        if (!stall) begin
          pc_d    = pc_q + IncVal;
          state_d = StFetch;
        end
      end
      StFlush: begin
        wait_d  = '0;
        state_d = StFetch;
      end
    endcase

    // Redirects override stall and imem_ready everywhere except BOOT.
    if (redirect && (state_q != StBoot)) begin
      pc_d    = redirect_pc;
      state_d = StFlush;
      wait_d  = '0;
      count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    end

    pc_plus4_d = pc_d + IncVal;
    imem_req_d = (state_d == StFetch);
    flush_d    = (state_d == StFlush);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + IncVal;
      imem_req_q <= 1'b0;
      flush_q    <= 1'b0;
      timeout_q  <= 1'b0;
      count_q    <= 16'd0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      imem_req_q <= imem_req_d;
      flush_q    <= flush_d;
      timeout_q  <= timeout_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
    end
  end

  assign imem_req       = imem_req_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_plus4_q;
  assign flush          = flush_q;
  assign fetch_timeout  = timeout_q;
  assign redirect_count = count_q;
  assign inst_valid     = (state_q == StFetch) && imem_ready;

endmodule
